// File: rtl/dist_filt_pkg.sv
// Shared types and default thresholds for the distance averaging filter.
// Distances are unsigned, in units of 0.001 cm.
package dist_filt_pkg;

  localparam int unsigned DIST_W = 19;

  localparam int unsigned DEF_MIN_DIST   = 2000;
  localparam int unsigned DEF_MAX_DIST   = 400000;
  localparam int unsigned DEF_ALARM_NEAR = 20000;
  localparam int unsigned DEF_ALARM_HYST = 2000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    LOST  = 2'd2
  } filt_state_t;

endpackage

// File: rtl/dist_win_buf.sv
// Circular sample window with a running sum. Prefill loads every entry with one
// sample, update replaces the oldest entry, clear empties the sum.
module dist_win_buf
  import dist_filt_pkg::*;
#(
  parameter int unsigned LOG2_N = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     clear,
  input  logic                     prefill,
  input  logic                     update,
  input  logic [DIST_W-1:0]        din,
  output logic [DIST_W+LOG2_N-1:0] sum
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = DIST_W + LOG2_N;

  logic [DIST_W-1:0] win [N];
  logic [LOG2_N-1:0] wptr;
  logic [SUM_W-1:0]  sum_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr  <= '0;
      sum_q <= '0;
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      sum_q <= '0;
    end else if (prefill) begin
      wptr  <= '0;
      sum_q <= SUM_W'(din) << LOG2_N;
      for (int i = 0; i < N; i++) win[i] <= din;
    end else if (update) begin
      // Sum width leaves LOG2_N bits of headroom, so this never wraps.
      win[wptr] <= din;
      sum_q     <= sum_q - SUM_W'(win[wptr]) + SUM_W'(din);
      wptr      <= wptr + LOG2_N'(1);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/dist_avg_filter.sv
// Range-gated sliding-window average of ultrasonic distance samples with
// loss-of-target tracking. Proximity alarm is built only with DIST_ALARM_EN.
//   state | meaning
//   EMPTY | window holds no samples; next accepted sample prefills it
//   RUN   | averaging; consecutive rejections are counted
//   LOST  | target lost, output forced to 0; next accepted sample prefills
module dist_avg_filter
  import dist_filt_pkg::*;
#(
  parameter int unsigned LOG2_N     = 2,
  parameter int unsigned MIN_DIST   = DEF_MIN_DIST,
  parameter int unsigned MAX_DIST   = DEF_MAX_DIST,
  parameter int unsigned REJ_LIMIT  = 3,
  parameter int unsigned ALARM_NEAR = DEF_ALARM_NEAR,
  parameter int unsigned ALARM_HYST = DEF_ALARM_HYST
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DIST_W-1:0] din,
  input  logic              din_vld,
  input  logic              flush,
  output logic [DIST_W-1:0] dout,
  output logic              dout_vld,
  output logic              lost,
  output logic              alarm
);

  localparam int unsigned       SUM_W    = DIST_W + LOG2_N;
  localparam logic [DIST_W-1:0] MIN_D    = DIST_W'(MIN_DIST);
  localparam logic [DIST_W-1:0] MAX_D    = DIST_W'(MAX_DIST);
  localparam logic [3:0]        REJ_LAST = 4'(REJ_LIMIT - 1);

  if (LOG2_N < 1 || LOG2_N > 4) begin : g_bad_log2_n
    $error("dist_avg_filter: LOG2_N must be 1..4");
  end
  if (REJ_LIMIT < 1 || REJ_LIMIT > 15) begin : g_bad_rej_limit
    $error("dist_avg_filter: REJ_LIMIT must be 1..15");
  end
  if ((ALARM_NEAR + ALARM_HYST) >= (1 << DIST_W)) begin : g_bad_alarm
    $error("dist_avg_filter: ALARM_NEAR + ALARM_HYST exceeds the distance range");
  end

  filt_state_t       state;
  logic [3:0]        rej_cnt;
  logic              s1_acc;
  logic              s1_lost_entry;
  logic              in_range;
  logic              accept;
  logic              reject;
  logic [SUM_W-1:0]  sum;
  logic [DIST_W-1:0] avg;

  assign in_range = (din >= MIN_D) && (din <= MAX_D);
  assign accept   = din_vld && in_range && !flush;
  assign reject   = din_vld && !in_range && !flush;
  assign avg      = sum[SUM_W-1:LOG2_N];

  dist_win_buf #(.LOG2_N(LOG2_N)) u_win (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (flush),
    .prefill(accept && (state != RUN)),
    .update (accept && (state == RUN)),
    .din    (din),
    .sum    (sum)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= EMPTY;
      rej_cnt       <= '0;
      s1_acc        <= 1'b0;
      s1_lost_entry <= 1'b0;
      dout          <= '0;
      dout_vld      <= 1'b0;
      lost          <= 1'b0;
    end else begin
      s1_acc        <= accept;
      s1_lost_entry <= 1'b0;

      // Stage 2 reads the sum already updated by stage 1.
      dout_vld <= s1_acc || s1_lost_entry;
      if (s1_lost_entry)
        dout <= '0;
      else if (s1_acc)
        dout <= avg;

      if (flush)
        lost <= 1'b0;
      else if (s1_lost_entry)
        lost <= 1'b1;
      else if (s1_acc)
        lost <= 1'b0;

      if (flush) begin
        state   <= EMPTY;
        rej_cnt <= '0;
      end else begin
        case (state)
          EMPTY: if (accept) state <= RUN;
          RUN: begin
            if (accept) begin
              rej_cnt <= '0;
            end else if (reject) begin
              if (rej_cnt == REJ_LAST) begin
                state         <= LOST;
                rej_cnt       <= '0;
                s1_lost_entry <= 1'b1;
              end else begin
                rej_cnt <= rej_cnt + 4'd1;
              end
            end
          end
          LOST:    if (accept) state <= RUN;
          default: state <= EMPTY;
        endcase
      end
    end
  end

`ifdef DIST_ALARM_EN
  localparam logic [DIST_W-1:0] NEAR_D = DIST_W'(ALARM_NEAR);
  localparam logic [DIST_W-1:0] CLR_D  = DIST_W'(ALARM_NEAR + ALARM_HYST);

  // Evaluated on the same edge that publishes dout, so alarm tracks dout_vld.
  always_ff @(posedge Clk) begin
    if (Rst || flush || s1_lost_entry) begin
      alarm <= 1'b0;
    end else if (s1_acc) begin
      if (avg < NEAR_D)
        alarm <= 1'b1;
      else if (avg >= CLR_D)
        alarm <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_dist_avg_filter.sv
// Directed self-checking bench for dist_avg_filter (LOG2_N=2, REJ_LIMIT=3),
// with alarm expectations that follow DIST_ALARM_EN.
module tb_dist_avg_filter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [18:0] din = '0;
  logic        din_vld = 1'b0;
  logic        flush = 1'b0;
  logic [18:0] dout;
  logic        dout_vld;
  logic        lost;
  logic        alarm;

  int checks = 0;
  int errors = 0;

`ifdef DIST_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  dist_avg_filter #(
    .LOG2_N   (2),
    .REJ_LIMIT(3)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .din     (din),
    .din_vld (din_vld),
    .flush   (flush),
    .dout    (dout),
    .dout_vld(dout_vld),
    .lost    (lost),
    .alarm   (alarm)
  );

  always #10 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [18:0] v, input logic f);
    @(negedge Clk);
    din     = v;
    din_vld = 1'b1;
    flush   = f;
    @(negedge Clk);
    din_vld = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
  endtask

  // Called one cycle after the strobe; output must appear exactly one cycle later.
  task automatic expect_out(input string tag, input logic [31:0] ed, input logic el,
                            input logic ea);
    chk({tag, "/early"}, 32'(dout_vld), 0);
    @(negedge Clk);
    chk({tag, "/vld"}, 32'(dout_vld), 1);
    chk({tag, "/dout"}, 32'(dout), ed);
    chk({tag, "/lost"}, 32'(lost), 32'(el));
    chk({tag, "/alarm"}, 32'(alarm), 32'(ALARM_ON & ea));
  endtask

  task automatic expect_none(input string tag, input logic [31:0] hold);
    chk({tag, "/vld1"}, 32'(dout_vld), 0);
    @(negedge Clk);
    chk({tag, "/vld2"}, 32'(dout_vld), 0);
    chk({tag, "/hold"}, 32'(dout), hold);
  endtask

  logic [18:0] floor_exp [4];

  initial begin
    floor_exp = '{19'd100000, 19'd100001, 19'd100002, 19'd100003};

    repeat (3) @(negedge Clk);
    chk("reset/dout", 32'(dout), 0);
    chk("reset/vld", 32'(dout_vld), 0);
    chk("reset/lost", 32'(lost), 0);
    chk("reset/alarm", 32'(alarm), 0);
    Rst = 1'b0;

    // First sample prefills the window; then running updates.
    sample(19'd100000, 1'b0); expect_out("first", 100000, 1'b0, 1'b0);
    sample(19'd104000, 1'b0); expect_out("upd1", 101000, 1'b0, 1'b0);
    sample(19'd108000, 1'b0); expect_out("upd2", 103000, 1'b0, 1'b0);

    // Floor division, back-to-back strobes.
    do_flush();
    sample(19'd100000, 1'b0); expect_out("refill", 100000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      if (i >= 2 && i < 6) begin
        chk("b2b/vld", 32'(dout_vld), 1);
        chk("b2b/dout", 32'(dout), 32'(floor_exp[i-2]));
      end
      if (i == 6) chk("b2b/idle", 32'(dout_vld), 0);
      din     = 19'd100003;
      din_vld = (i < 4);
    end

    // Loss of target after three consecutive rejections.
    sample(19'd450000, 1'b0); expect_none("rej1", 100003);
    sample(19'd450000, 1'b0); expect_none("rej2", 100003);
    sample(19'd450000, 1'b0); expect_out("lost_entry", 0, 1'b1, 1'b0);
    @(negedge Clk);
    chk("lost/single_pulse", 32'(dout_vld), 0);
    chk("lost/held", 32'(lost), 1);
    sample(19'd50000, 1'b0); expect_out("reacquire", 50000, 1'b0, 1'b0);

    // Range boundaries; an accepted sample clears the rejection count.
    sample(19'd1999, 1'b0);   expect_none("below_min", 50000);
    sample(19'd2000, 1'b0);   expect_out("at_min", 38000, 1'b0, 1'b0);
    sample(19'd400001, 1'b0); expect_none("above_max1", 38000);
    sample(19'd400001, 1'b0); expect_none("above_max2", 38000);
    sample(19'd400000, 1'b0); expect_out("at_max", 125500, 1'b0, 1'b0);
    sample(19'd400001, 1'b0); expect_none("cnt_cleared", 125500);

    // flush beats a same-cycle sample; rejections in EMPTY are ignored.
    sample(19'd70000, 1'b1);  expect_none("flush_wins", 125500);
    sample(19'd450000, 1'b0); expect_none("empty_rej1", 125500);
    sample(19'd450000, 1'b0); expect_none("empty_rej2", 125500);
    sample(19'd450000, 1'b0); expect_none("empty_rej3", 125500);
    chk("empty/lost", 32'(lost), 0);
    sample(19'd30000, 1'b0);  expect_out("after_flush", 30000, 1'b0, 1'b0);

    // Sample in stage 2 survives a flush.
    @(negedge Clk);
    din     = 19'd34000;
    din_vld = 1'b1;
    @(negedge Clk);
    din_vld = 1'b0;
    flush   = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    chk("flush_s2/vld", 32'(dout_vld), 1);
    chk("flush_s2/dout", 32'(dout), 31000);
    sample(19'd60000, 1'b0); expect_out("flush_s2/empty", 60000, 1'b0, 1'b0);

    // Alarm thresholds with hysteresis.
    do_flush();
    sample(19'd19000, 1'b0); expect_out("alarm_set", 19000, 1'b0, 1'b1);
    sample(19'd27000, 1'b0); expect_out("alarm_hyst", 21000, 1'b0, 1'b1);
    sample(19'd23000, 1'b0); expect_out("alarm_clr", 22000, 1'b0, 1'b0);
    sample(19'd5000, 1'b0);  expect_out("alarm_reset", 18500, 1'b0, 1'b1);

    // Reset mid-flight drops the in-flight sample.
    @(negedge Clk);
    din     = 19'd80000;
    din_vld = 1'b1;
    @(negedge Clk);
    din_vld = 1'b0;
    Rst     = 1'b1;
    @(negedge Clk);
    chk("midrst/vld", 32'(dout_vld), 0);
    chk("midrst/dout", 32'(dout), 0);
    chk("midrst/lost", 32'(lost), 0);
    chk("midrst/alarm", 32'(alarm), 0);
    Rst = 1'b0;
    sample(19'd5000, 1'b0); expect_out("post_rst", 5000, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
